// File: rtl/sig_param_ctrl.sv
// rtl/sig_param_ctrl.sv - front-panel key debounce and edit/run control word for the signal generator
// Three active-low keys (ok, sel, inc) are synchronized, debounced and turned into one-cycle press pulses.
module sig_param_ctrl #(
   parameter int DEB_CYCLES = 1_000_000,
   parameter int FIELD_MAX  = 3
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic       key_sel,
   input  logic       key_inc,
   input  logic       key_ok,
   output logic [1:0] cnt_sig,
   output logic [1:0] cnt_amp,
   output logic [1:0] cnt_fre,
   output logic [1:0] cnt_phase,
   output logic       confirm,
   output logic [1:0] edit_field
);

   localparam int             CW       = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [1:0]     FMAX     = 2'(FIELD_MAX);

   localparam int K_INC = 0;
   localparam int K_SEL = 1;
   localparam int K_OK  = 2;

   typedef enum logic {
      ST_EDIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   logic [2:0]    raw_keys;
   logic [2:0]    sync1_q;
   logic [2:0]    sync2_q;
   logic [2:0]    level_q;
   logic [2:0]    level_d;
   logic [2:0]    press_q;
   logic [2:0]    press_d;
   logic [CW-1:0] cnt_q [3];
   logic [CW-1:0] cnt_d [3];

   state_t     state_q, state_d;
   logic [1:0] sig_q, sig_d;
   logic [1:0] amp_q, amp_d;
   logic [1:0] fre_q, fre_d;
   logic [1:0] phase_q, phase_d;
   logic [1:0] field_q, field_d;

   assign raw_keys = {key_ok, key_sel, key_inc};

   function automatic logic [1:0] wrap_inc(input logic [1:0] v);
      return (v >= FMAX) ? 2'd0 : v + 2'd1;
   endfunction

   // A level is accepted only after DEB_CYCLES consecutive differing samples.
   always_comb begin
      level_d = level_q;
      press_d = '0;
      for (int k = 0; k < 3; k++) begin
         cnt_d[k] = '0;
         if (sync2_q[k] != level_q[k]) begin
            if (cnt_q[k] == CNT_LAST) begin
               level_d[k] = sync2_q[k];
               press_d[k] = ~sync2_q[k];
            end else begin
               cnt_d[k] = cnt_q[k] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
         level_q <= '1;
         press_q <= '0;
         for (int k = 0; k < 3; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         sync1_q <= raw_keys;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         for (int k = 0; k < 3; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   // Simultaneous pulses resolve ok > sel > inc; losers are dropped.
   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      amp_d   = amp_q;
      fre_d   = fre_q;
      phase_d = phase_q;
      field_d = field_q;
      case (state_q)
         ST_EDIT: begin
            if (press_q[K_OK]) begin
               state_d = ST_RUN;
            end else if (press_q[K_SEL]) begin
               field_d = field_q + 2'd1;
            end else if (press_q[K_INC]) begin
               case (field_q)
                  2'd0:    sig_d   = wrap_inc(sig_q);
                  2'd1:    amp_d   = wrap_inc(amp_q);
                  2'd2:    fre_d   = wrap_inc(fre_q);
                  default: phase_d = wrap_inc(phase_q);
               endcase
            end
         end
         ST_RUN: begin
            if (press_q[K_OK]) begin
               state_d = ST_EDIT;
            end
         end
         default: state_d = ST_EDIT;
      endcase
   end

   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state_q <= ST_EDIT;
         sig_q   <= 2'd0;
         amp_q   <= 2'd1;
         fre_q   <= 2'd0;
         phase_q <= 2'd0;
         field_q <= 2'd0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         amp_q   <= amp_d;
         fre_q   <= fre_d;
         phase_q <= phase_d;
         field_q <= field_d;
      end
   end

   assign cnt_sig    = sig_q;
   assign cnt_amp    = amp_q;
   assign cnt_fre    = fre_q;
   assign cnt_phase  = phase_q;
   assign confirm    = (state_q == ST_RUN);
   assign edit_field = field_q;

endmodule

// File: tb/tb_sig_param_ctrl.sv
// tb/tb_sig_param_ctrl.sv - self-checking bench for sig_param_ctrl
// Vector table of key presses with a scoreboard queue of expected control words.
module tb_sig_param_ctrl;

   localparam int DEB = 4;
   localparam int NV  = 23;

   typedef struct packed {
      logic [1:0] sig;
      logic [1:0] amp;
      logic [1:0] fre;
      logic [1:0] phase;
      logic       conf;
      logic [1:0] field;
   } exp_t;

   typedef struct packed {
      logic [2:0] keys;   // {ok, sel, inc}, 1 = pressed
      exp_t       e;
   } vec_t;

   logic       clk_50M = 1'b0;
   logic       rst_n   = 1'b0;
   logic       key_sel = 1'b1;
   logic       key_inc = 1'b1;
   logic       key_ok  = 1'b1;
   logic [1:0] cnt_sig, cnt_amp, cnt_fre, cnt_phase, edit_field;
   logic       confirm;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t cur_exp;
   exp_t sb[$];
   vec_t vecs [NV];

   sig_param_ctrl #(.DEB_CYCLES(DEB), .FIELD_MAX(3)) dut (
      .clk_50M    (clk_50M),
      .rst_n      (rst_n),
      .key_sel    (key_sel),
      .key_inc    (key_inc),
      .key_ok     (key_ok),
      .cnt_sig    (cnt_sig),
      .cnt_amp    (cnt_amp),
      .cnt_fre    (cnt_fre),
      .cnt_phase  (cnt_phase),
      .confirm    (confirm),
      .edit_field (edit_field)
   );

   always #10 clk_50M = ~clk_50M;

   function automatic exp_t mk_exp(input int s, input int a, input int f, input int p,
                                   input int c, input int fld);
      exp_t e;
      e.sig   = 2'(s);
      e.amp   = 2'(a);
      e.fre   = 2'(f);
      e.phase = 2'(p);
      e.conf  = 1'(c);
      e.field = 2'(fld);
      return e;
   endfunction

   function automatic vec_t mk(input logic [2:0] k, input int s, input int a, input int f,
                               input int p, input int c, input int fld);
      vec_t v;
      v.keys = k;
      v.e    = mk_exp(s, a, f, p, c, fld);
      return v;
   endfunction

   task automatic check(input string name, input exp_t e);
      exp_t act;
      act = '{cnt_sig, cnt_amp, cnt_fre, cnt_phase, confirm, edit_field};
      n_tests++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL %s: got sig=%0d amp=%0d fre=%0d ph=%0d conf=%0d fld=%0d, want sig=%0d amp=%0d fre=%0d ph=%0d conf=%0d fld=%0d",
                  name, act.sig, act.amp, act.fre, act.phase, act.conf, act.field,
                  e.sig, e.amp, e.fre, e.phase, e.conf, e.field);
      end
   endtask

   // Press the keys in m, check the exact output edge, release and check nothing moves.
   task automatic press(input logic [2:0] m, input int idx);
      exp_t e;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_empty: vector %0d has no expectation", idx);
         return;
      end
      e = sb.pop_front();
      @(negedge clk_50M);
      key_ok  = ~m[2];
      key_sel = ~m[1];
      key_inc = ~m[0];
      repeat (2 + DEB) @(negedge clk_50M);
      check($sformatf("v%0d_early", idx), cur_exp);
      @(negedge clk_50M);
      check($sformatf("v%0d_edge", idx), e);
      key_ok  = 1'b1;
      key_sel = 1'b1;
      key_inc = 1'b1;
      repeat (2 + DEB + 3) @(negedge clk_50M);
      check($sformatf("v%0d_release", idx), e);
      cur_exp = e;
   endtask

   initial begin
      vecs[0]  = mk(3'b010, 1, 1, 0, 0, 0, 1);
      vecs[1]  = mk(3'b001, 1, 2, 0, 0, 0, 1);
      vecs[2]  = mk(3'b001, 1, 3, 0, 0, 0, 1);
      vecs[3]  = mk(3'b001, 1, 0, 0, 0, 0, 1);
      vecs[4]  = mk(3'b100, 1, 0, 0, 0, 1, 1);
      vecs[5]  = mk(3'b001, 1, 0, 0, 0, 1, 1);
      vecs[6]  = mk(3'b010, 1, 0, 0, 0, 1, 1);
      vecs[7]  = mk(3'b100, 1, 0, 0, 0, 0, 1);
      vecs[8]  = mk(3'b101, 1, 0, 0, 0, 1, 1);
      vecs[9]  = mk(3'b100, 1, 0, 0, 0, 0, 1);
      vecs[10] = mk(3'b011, 1, 0, 0, 0, 0, 2);
      vecs[11] = mk(3'b001, 1, 0, 1, 0, 0, 2);
      vecs[12] = mk(3'b010, 1, 0, 1, 0, 0, 3);
      vecs[13] = mk(3'b001, 1, 0, 1, 1, 0, 3);
      vecs[14] = mk(3'b010, 1, 0, 1, 1, 0, 0);
      vecs[15] = mk(3'b001, 2, 0, 1, 1, 0, 0);
      vecs[16] = mk(3'b001, 3, 0, 1, 1, 0, 0);
      vecs[17] = mk(3'b001, 0, 0, 1, 1, 0, 0);
      vecs[18] = mk(3'b010, 0, 0, 1, 1, 0, 1);
      vecs[19] = mk(3'b001, 0, 1, 1, 1, 0, 1);
      vecs[20] = mk(3'b001, 0, 2, 1, 1, 0, 1);
      vecs[21] = mk(3'b001, 0, 3, 1, 1, 0, 1);
      vecs[22] = mk(3'b100, 0, 3, 1, 1, 1, 1);

      // Reset held for two cycles
      rst_n = 1'b0;
      repeat (2) @(negedge clk_50M);
      cur_exp = mk_exp(0, 1, 0, 0, 0, 0);
      check("reset", cur_exp);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_50M);
      check("idle", cur_exp);

      // Bouncing inc key, then a solid hold: exactly one increment
      for (int b = 0; b < 3; b++) begin
         key_inc = 1'b1;
         repeat (2) @(negedge clk_50M);
         key_inc = 1'b0;
         repeat (2) @(negedge clk_50M);
      end
      key_inc = 1'b1;
      @(negedge clk_50M);
      check("bounce_none", cur_exp);
      key_inc = 1'b0;
      repeat (12) @(negedge clk_50M);
      cur_exp = mk_exp(1, 1, 0, 0, 0, 0);
      check("bounce_hold", cur_exp);
      key_inc = 1'b1;
      repeat (12) @(negedge clk_50M);
      check("bounce_release", cur_exp);

      for (int i = 0; i < NV; i++) begin
         sb.push_back(vecs[i].e);
         press(vecs[i].keys, i);
      end

      // One-cycle reset while running with amp=3
      @(negedge clk_50M);
      rst_n = 1'b0;
      @(negedge clk_50M);
      rst_n = 1'b1;
      cur_exp = mk_exp(0, 1, 0, 0, 0, 0);
      check("reset_in_run", cur_exp);

      // Key held low across reset deassertion yields one press
      key_inc = 1'b0;
      @(negedge clk_50M);
      rst_n = 1'b0;
      @(negedge clk_50M);
      rst_n = 1'b1;
      repeat (2 + DEB) @(negedge clk_50M);
      check("held_reset_early", cur_exp);
      @(negedge clk_50M);
      cur_exp = mk_exp(1, 1, 0, 0, 0, 0);
      check("held_reset_press", cur_exp);
      repeat (10) @(negedge clk_50M);
      check("held_reset_once", cur_exp);
      key_inc = 1'b1;
      repeat (10) @(negedge clk_50M);
      check("held_reset_release", cur_exp);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
